// File: rtl/lsi_port_param.sv
// lsi_port_param: low-speed serial link between the EZ-USB host firmware and
// FPGA user logic, presenting an SRAM-like write/read port of configurable
// width. The host clocks frames with data_clk (both polarities count), frames
// are closed by stop, and read data is returned over an open-drain pin.
module lsi_port_param #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter bit          AUTO_INC     = 1'b1,
  parameter int unsigned IDLE_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_clk,
  input  logic                  data_i,
  output logic                  data_oe,
  input  logic                  stop,
  output logic [ADDR_WIDTH-1:0] in_addr,
  output logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_strobe,
  output logic                  in_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  input  logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_strobe,
  output logic                  frame_err,
  output logic                  timeout_err
);

  localparam int unsigned FrameW = DATA_WIDTH + ADDR_WIDTH;
  localparam int unsigned BitW   = $clog2(FrameW + 1);
  localparam int unsigned TxW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned IdleW  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  localparam logic [BitW-1:0]       BitFull  = BitW'(FrameW);
  localparam logic [BitW-1:0]       BitAddr  = BitW'(ADDR_WIDTH);
  localparam logic [TxW-1:0]        TxLast   = TxW'(DATA_WIDTH - 1);
  localparam logic [IdleW-1:0]      IdleLast = IdleW'(IDLE_TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(AUTO_INC);

  typedef enum logic [1:0] {StRx, StTxLoad, StTxShift} state_e;

  state_e                  state_q;
  logic [2:0]              dclk_hist_q;
  logic [FrameW-1:0]       rx_reg_q;
  logic [BitW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0]   tx_reg_q;
  logic [TxW-1:0]          tx_cnt_q;
  logic [IdleW-1:0]        idle_cnt_q;

  logic clk_edge;
  logic rx_mode;

  // A data_clk transition counts once the previous two samples agreed, so a
  // single toggle yields exactly one edge cycle.
  assign clk_edge = (dclk_hist_q[0] ^ dclk_hist_q[1]) & ~(dclk_hist_q[1] ^ dclk_hist_q[2]);

  // Stop low during a transfer drops back to receive in the same cycle, so an
  // edge arriving then is handled as a receive edge.
  assign rx_mode = (state_q == StRx) || !stop;

  // Open-drain drive: pull low for a 0 bit while transmitting.
  assign data_oe = (state_q != StRx) && !tx_reg_q[0];

  // Sample history of the host bit clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      dclk_hist_q <= '0;
    end else begin
      dclk_hist_q <= {dclk_hist_q[1:0], data_clk};
    end
  end

  // Frame receive, read-burst transmit and the registered status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRx;
      rx_reg_q    <= '0;
      bit_cnt_q   <= '0;
      tx_reg_q    <= '0;
      tx_cnt_q    <= '0;
      idle_cnt_q  <= '0;
      in_addr     <= '0;
      in_data     <= '0;
      in_strobe   <= 1'b0;
      in_valid    <= 1'b0;
      out_addr    <= '0;
      out_strobe  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      in_strobe   <= 1'b0;
      out_strobe  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;

      if (rx_mode) begin
        state_q  <= StRx;
        tx_cnt_q <= '0;
        if (clk_edge) begin
          idle_cnt_q <= '0;
          if (!stop) begin
            // Bits arrive LSB first; the last ADDR_WIDTH bits land on top.
            rx_reg_q <= {data_i, rx_reg_q[FrameW-1:1]};
            if (bit_cnt_q != BitFull) begin
              bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
          end else begin
            bit_cnt_q <= '0;
            if (!data_i) begin
              if (bit_cnt_q == BitFull) begin
                in_addr   <= rx_reg_q[FrameW-1:DATA_WIDTH];
                in_data   <= rx_reg_q[DATA_WIDTH-1:0];
                in_valid  <= 1'b1;
                in_strobe <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              if (bit_cnt_q >= BitAddr) begin
                out_addr   <= rx_reg_q[FrameW-1:DATA_WIDTH];
                out_strobe <= 1'b1;
                state_q    <= StTxLoad;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end
        end else if ((IDLE_TIMEOUT != 0) && (bit_cnt_q != '0)) begin
          if (idle_cnt_q == IdleLast) begin
            bit_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            timeout_err <= 1'b1;
          end else begin
            idle_cnt_q <= idle_cnt_q + IdleW'(1);
          end
        end else begin
          idle_cnt_q <= '0;
        end
      end else begin
        idle_cnt_q <= '0;
        unique case (state_q)
          StTxLoad: begin
            // Track user data until the host clocks out the first bit.
            tx_reg_q <= out_data;
            if (clk_edge) begin
              if (DATA_WIDTH == 1) begin
                out_addr   <= out_addr + AddrStep;
                out_strobe <= 1'b1;
              end else begin
                tx_reg_q <= tx_reg_q >> 1;
                tx_cnt_q <= TxW'(1);
                state_q  <= StTxShift;
              end
            end
          end
          StTxShift: begin
            if (clk_edge) begin
              if (tx_cnt_q == TxLast) begin
                tx_cnt_q   <= '0;
                out_addr   <= out_addr + AddrStep;
                out_strobe <= 1'b1;
                state_q    <= StTxLoad;
              end else begin
                tx_reg_q <= tx_reg_q >> 1;
                tx_cnt_q <= tx_cnt_q + TxW'(1);
              end
            end
          end
          default: state_q <= StRx;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsi_port_param.sv
// Bench for lsi_port_param: four instances (default, no auto-increment,
// short idle timeout, 16/4 widths) driven one at a time through directed and
// random frames, checked against a transaction-level model of the link.
module tb_lsi_port_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [3:0]       dclk, din, stp;
  logic [3:0]       oe, istb, ival, ostb, ferr, terr;
  logic [3:0][31:0] idat, odata;
  logic [3:0][7:0]  iadr, oadr;
  logic [15:0]      idat3;
  logic [3:0]       iadr3, oadr3;

  assign idat[3] = {16'h0, idat3};
  assign iadr[3] = {4'h0, iadr3};
  assign oadr[3] = {4'h0, oadr3};

  // User register map stub: read data is a byte-replicated address.
  always_comb begin
    for (int k = 0; k < 4; k++) odata[k] = {24'h0, oadr[k]} * 32'h0101_0101;
  end

  lsi_port_param u_dut0 (
    .clk(clk), .reset(reset), .data_clk(dclk[0]), .data_i(din[0]), .data_oe(oe[0]),
    .stop(stp[0]), .in_addr(iadr[0]), .in_data(idat[0]), .in_strobe(istb[0]),
    .in_valid(ival[0]), .out_addr(oadr[0]), .out_data(odata[0]), .out_strobe(ostb[0]),
    .frame_err(ferr[0]), .timeout_err(terr[0])
  );

  lsi_port_param #(.AUTO_INC(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .data_clk(dclk[1]), .data_i(din[1]), .data_oe(oe[1]),
    .stop(stp[1]), .in_addr(iadr[1]), .in_data(idat[1]), .in_strobe(istb[1]),
    .in_valid(ival[1]), .out_addr(oadr[1]), .out_data(odata[1]), .out_strobe(ostb[1]),
    .frame_err(ferr[1]), .timeout_err(terr[1])
  );

  lsi_port_param #(.IDLE_TIMEOUT(100)) u_dut2 (
    .clk(clk), .reset(reset), .data_clk(dclk[2]), .data_i(din[2]), .data_oe(oe[2]),
    .stop(stp[2]), .in_addr(iadr[2]), .in_data(idat[2]), .in_strobe(istb[2]),
    .in_valid(ival[2]), .out_addr(oadr[2]), .out_data(odata[2]), .out_strobe(ostb[2]),
    .frame_err(ferr[2]), .timeout_err(terr[2])
  );

  lsi_port_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) u_dut3 (
    .clk(clk), .reset(reset), .data_clk(dclk[3]), .data_i(din[3]), .data_oe(oe[3]),
    .stop(stp[3]), .in_addr(iadr3), .in_data(idat3), .in_strobe(istb[3]),
    .in_valid(ival[3]), .out_addr(oadr3), .out_data(odata[3][15:0]), .out_strobe(ostb[3]),
    .frame_err(ferr[3]), .timeout_err(terr[3])
  );

  int tests = 0;
  int fails = 0;

  // Pulse counters per instance.
  int n_istb[4], n_ostb[4], n_ferr[4], n_terr[4];
  initial for (int k = 0; k < 4; k++) begin
    n_istb[k] = 0; n_ostb[k] = 0; n_ferr[k] = 0; n_terr[k] = 0;
  end
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (istb[k] === 1'b1) n_istb[k]++;
      if (ostb[k] === 1'b1) n_ostb[k]++;
      if (ferr[k] === 1'b1) n_ferr[k]++;
      if (terr[k] === 1'b1) n_terr[k]++;
    end
  end

  // Reference model state.
  logic [31:0] m_idat[4];
  logic [7:0]  m_iadr[4], m_oadr[4];
  logic        m_ival[4];

  function automatic int aw_of(input int k);
    return (k == 3) ? 4 : 8;
  endfunction
  function automatic int dw_of(input int k);
    return (k == 3) ? 16 : 32;
  endfunction
  function automatic int inc_of(input int k);
    return (k == 1) ? 0 : 1;
  endfunction
  function automatic logic [31:0] amask(input int k);
    return (32'd1 << aw_of(k)) - 32'd1;
  endfunction
  function automatic logic [31:0] dmask(input int k);
    return (dw_of(k) == 32) ? 32'hFFFF_FFFF : ((32'd1 << dw_of(k)) - 32'd1);
  endfunction
  function automatic logic [31:0] word_of(input int k, input logic [31:0] a);
    return (a * 32'h0101_0101) & dmask(k);
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s inst%0d: observed %0h, expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One host clock transition, then respect the minimum edge spacing.
  task automatic send_edge(input int k, input logic d, input logic s);
    din[k]  = d;
    stp[k]  = s;
    dclk[k] = ~dclk[k];
    tick(6);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dclk  = '0;
    din   = '0;
    stp   = '0;
    tick(1);
    for (int k = 0; k < 4; k++) check("rst_data_oe_next", k, {31'b0, oe[k]}, 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);
    for (int k = 0; k < 4; k++) begin
      m_idat[k] = '0; m_iadr[k] = '0; m_oadr[k] = '0; m_ival[k] = 1'b0;
      check("rst_in_addr", k, {24'b0, iadr[k]}, 32'd0);
      check("rst_in_data", k, idat[k], 32'd0);
      check("rst_in_valid", k, {31'b0, ival[k]}, 32'd0);
      check("rst_out_addr", k, {24'b0, oadr[k]}, 32'd0);
      check("rst_pulses", k, {28'b0, istb[k], ostb[k], ferr[k], terr[k]}, 32'd0);
    end
  endtask

  task automatic write_frame(input int k, input logic [31:0] addr, input logic [31:0] data);
    int bi, bf;
    logic [31:0] a, d;
    a  = addr & amask(k);
    d  = data & dmask(k);
    bi = n_istb[k];
    bf = n_ferr[k];
    for (int i = 0; i < dw_of(k); i++) send_edge(k, d[i], 1'b0);
    for (int i = 0; i < aw_of(k); i++) send_edge(k, a[i], 1'b0);
    send_edge(k, 1'b0, 1'b1);
    m_iadr[k] = a[7:0];
    m_idat[k] = d;
    m_ival[k] = 1'b1;
    check("wr_in_strobe_count", k, 32'(n_istb[k] - bi), 32'd1);
    check("wr_frame_err_count", k, 32'(n_ferr[k] - bf), 32'd0);
    check("wr_in_addr", k, {24'b0, iadr[k]}, {24'b0, m_iadr[k]});
    check("wr_in_data", k, idat[k], m_idat[k]);
    check("wr_in_valid", k, {31'b0, ival[k]}, 32'd1);
  endtask

  // Commit too few bits; rd selects a read or a write commit.
  task automatic short_frame(input int k, input int nbits, input logic rd);
    int bi, bo, bf;
    bi = n_istb[k];
    bo = n_ostb[k];
    bf = n_ferr[k];
    for (int i = 0; i < nbits; i++) send_edge(k, 1'($urandom), 1'b0);
    send_edge(k, rd, 1'b1);
    check("short_frame_err_count", k, 32'(n_ferr[k] - bf), 32'd1);
    check("short_in_strobe_count", k, 32'(n_istb[k] - bi), 32'd0);
    check("short_out_strobe_count", k, 32'(n_ostb[k] - bo), 32'd0);
    check("short_in_addr", k, {24'b0, iadr[k]}, {24'b0, m_iadr[k]});
    check("short_in_data", k, idat[k], m_idat[k]);
    check("short_in_valid", k, {31'b0, ival[k]}, {31'b0, m_ival[k]});
    check("short_no_tx", k, {31'b0, oe[k]}, 32'd0);
  endtask

  task automatic start_read(input int k, input logic [31:0] addr);
    int bo;
    logic [31:0] a;
    a  = addr & amask(k);
    bo = n_ostb[k];
    for (int i = 0; i < aw_of(k); i++) send_edge(k, a[i], 1'b0);
    send_edge(k, 1'b1, 1'b1);
    m_oadr[k] = a[7:0];
    check("rd_cmd_out_strobe_count", k, 32'(n_ostb[k] - bo), 32'd1);
    check("rd_cmd_out_addr", k, {24'b0, oadr[k]}, {24'b0, m_oadr[k]});
  endtask

  // Clock out n bits of the current word, checking each before its edge.
  task automatic tx_bits(input int k, input int n);
    logic [31:0] w;
    w = word_of(k, {24'b0, m_oadr[k]});
    for (int b = 0; b < n; b++) begin
      check("tx_data_oe", k, {31'b0, oe[k]}, {31'b0, ~w[b]});
      send_edge(k, 1'b0, 1'b1);
    end
  endtask

  task automatic read_words(input int k, input int nwords);
    int bo;
    for (int w = 0; w < nwords; w++) begin
      bo = n_ostb[k];
      tx_bits(k, dw_of(k));
      m_oadr[k] = 8'((({24'b0, m_oadr[k]} + 32'(inc_of(k))) & amask(k)));
      check("tx_word_out_strobe_count", k, 32'(n_ostb[k] - bo), 32'd1);
      check("tx_word_out_addr", k, {24'b0, oadr[k]}, {24'b0, m_oadr[k]});
    end
  endtask

  // Release stop; the open-drain drive must drop on the following cycle.
  task automatic end_tx(input int k);
    stp[k] = 1'b0;
    tick(1);
    check("stop_low_data_oe", k, {31'b0, oe[k]}, 32'd0);
    tick(3);
    check("stop_low_out_addr", k, {24'b0, oadr[k]}, {24'b0, m_oadr[k]});
  endtask

  initial begin
    int bt, k, op;
    reset = 1'b1;
    dclk  = '0;
    din   = '0;
    stp   = '0;
    tick(2);
    do_reset();

    // Directed write, short frames and burst reads on the default instance.
    write_frame(0, 32'h5A, 32'hDEAD_BEEF);
    short_frame(0, 20, 1'b0);
    short_frame(0, 3, 1'b1);
    start_read(0, 32'h10);
    read_words(0, 3);
    end_tx(0);

    // Address wrap with and without auto-increment.
    start_read(0, 32'hFF);
    read_words(0, 2);
    end_tx(0);
    start_read(1, 32'hFF);
    read_words(1, 2);
    end_tx(1);

    // Idle timeout discards a partial frame and clears the bit count.
    bt = n_terr[2];
    for (int i = 0; i < 5; i++) send_edge(2, 1'b1, 1'b0);
    tick(94);
    check("timeout_not_early", 2, 32'(n_terr[2] - bt), 32'd0);
    tick(4);
    check("timeout_pulse", 2, 32'(n_terr[2] - bt), 32'd1);
    short_frame(2, 35, 1'b0);
    write_frame(2, 32'hC3, 32'h1234_5678);
    bt = n_terr[2];
    tick(120);
    check("timeout_idle_after_commit", 2, 32'(n_terr[2] - bt), 32'd0);
    check("timeout_default_quiet", 0, 32'(n_terr[0]), 32'd0);

    // Reset and stop-low abort mid-word on both widths.
    for (int j = 0; j < 2; j++) begin
      k = (j == 0) ? 0 : 3;
      start_read(k, $urandom);
      tx_bits(k, 5);
      do_reset();
      write_frame(k, $urandom, $urandom);
      start_read(k, $urandom);
      tx_bits(k, 7);
      end_tx(k);
      write_frame(k, $urandom, $urandom);
      start_read(k, $urandom);
      read_words(k, 1);
      end_tx(k);
    end

    // Random traffic across all instances.
    for (int it = 0; it < 24; it++) begin
      k  = $urandom_range(0, 3);
      op = $urandom_range(0, 3);
      case (op)
        0: write_frame(k, $urandom, $urandom);
        1: begin
          start_read(k, $urandom);
          read_words(k, $urandom_range(1, 2));
          end_tx(k);
        end
        2: short_frame(k, $urandom_range(0, dw_of(k) + aw_of(k) - 1), 1'b0);
        default: short_frame(k, $urandom_range(0, aw_of(k) - 1), 1'b1);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
